// File: rtl/ddr_pkg.sv
// Shared types and sizing helpers for the DDR serializer.
// DDR_PARITY_EN adds a parity trailer cycle, which changes the cycles-per-word count.
package ddr_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

`ifdef DDR_PARITY_EN
   localparam bit PARITY_EN = 1'b1;
`else
   localparam bit PARITY_EN = 1'b0;
`endif

   // Line cycles occupied by one word (CYC).
   function automatic int ddr_cyc(input int dw);
      return PARITY_EN ? (dw / 2 + 1) : (dw / 2);
   endfunction

   function automatic int ddr_cnt_w(input int dw);
      return $clog2(ddr_cyc(dw) + 1);
   endfunction

endpackage

// File: rtl/ddr_serializer_if.sv
// Word handshake into the DDR serializer: the source drives data/valid, the serializer drives ready.
interface ddr_serializer_if #(
   parameter int DW = 8
) ();
   logic [DW-1:0] i_data;
   logic          i_valid;
   logic          o_ready;

   modport master (output i_data, output i_valid, input o_ready);
   modport slave  (input i_data, input i_valid, output o_ready);
endinterface

// File: rtl/ddr_serializer_out_cell.sv
// DDR output cell: posedge rail, negedge rail and the clock-level mux onto the line.
module ddr_out_cell (
   input  logic i_clk,
   input  logic i_rstn,
   input  logic i_pos_d,
   input  logic i_neg_d,
   output logic o_q_pos,
   output logic o_q_neg,
   output logic o_ddr
);
   logic r_q_pos;
   logic r_q_neg;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) r_q_pos <= 1'b0;
      else         r_q_pos <= i_pos_d;
   end

   // Pure re-timing of the odd bit by half a cycle; no decisions here.
   always_ff @(negedge i_clk or negedge i_rstn) begin
      if (!i_rstn) r_q_neg <= 1'b0;
      else         r_q_neg <= i_neg_d;
   end

   assign o_q_pos = r_q_pos;
   assign o_q_neg = r_q_neg;
   assign o_ddr   = i_clk ? r_q_pos : r_q_neg;
endmodule

// File: rtl/ddr_serializer.sv
// DDR serializer: one holding buffer plus a shifter, sends 2 bits per i_clk cycle, bit 0 first.
// Optional: define DDR_PARITY_EN for an even-parity trailer cycle after each word.
module ddr_serializer
   import ddr_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   ddr_serializer_if.slave s_if,
   output logic            o_ddr,
   output logic            o_q_pos,
   output logic            o_q_neg,
   output logic            o_frame,
   output logic            o_sof
);
   localparam int            CYC       = ddr_cyc(DW);
   localparam int            CW        = ddr_cnt_w(DW);
   localparam logic [CW-1:0] LAST      = CW'(CYC - 1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DW / 2 - 1);

   state_t        r_state,    w_state_nxt;
   logic [CW-1:0] r_cnt,      w_cnt_nxt;
   logic [DW-1:0] r_buf,      w_buf_nxt;
   logic [DW-1:0] r_sh,       w_sh_nxt;
   logic          r_buf_full, w_buf_full_nxt;
   logic          r_neg_stage, w_neg_stage_nxt;
   logic          r_frame,    w_frame_nxt;
   logic          r_sof,      w_sof_nxt;
   logic          w_pos_d;
   logic          w_accept;
   logic          w_word_end;
`ifdef DDR_PARITY_EN
   logic          r_par,      w_par_nxt;
`endif

   assign s_if.o_ready = !r_buf_full;
   assign w_accept     = s_if.i_valid && !r_buf_full;
   assign w_word_end   = (r_state == IDLE) || (r_cnt == LAST);

   // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_buf_nxt       = r_buf;
      w_sh_nxt        = r_sh;
      w_buf_full_nxt  = r_buf_full;
      w_pos_d         = 1'b0;
      w_neg_stage_nxt = 1'b0;
      w_frame_nxt     = 1'b0;
      w_sof_nxt       = 1'b0;
`ifdef DDR_PARITY_EN
      w_par_nxt       = r_par;
`endif

      if (w_accept) begin
         w_buf_nxt      = s_if.i_data;
         w_buf_full_nxt = 1'b1;
      end

      if (w_word_end && r_buf_full) begin
         w_pos_d         = r_buf[0];
         w_neg_stage_nxt = r_buf[1];
         w_sh_nxt        = r_buf >> 2;
         w_cnt_nxt       = '0;
         w_buf_full_nxt  = 1'b0;
         w_state_nxt     = SHIFT;
         w_frame_nxt     = 1'b1;
         w_sof_nxt       = 1'b1;
`ifdef DDR_PARITY_EN
         w_par_nxt       = ^r_buf;
`endif
      end else if (r_state == SHIFT && r_cnt < DATA_LAST) begin
         w_pos_d         = r_sh[0];
         w_neg_stage_nxt = r_sh[1];
         w_sh_nxt        = r_sh >> 2;
         w_cnt_nxt       = r_cnt + 1'b1;
         w_frame_nxt     = 1'b1;
`ifdef DDR_PARITY_EN
      end else if (r_state == SHIFT && r_cnt == DATA_LAST) begin
         w_pos_d         = r_par;
         w_neg_stage_nxt = ~r_par;
         w_cnt_nxt       = r_cnt + 1'b1;
         w_frame_nxt     = 1'b1;
`endif
      end else if (r_state == SHIFT) begin
         w_state_nxt = IDLE;
         w_cnt_nxt   = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // NOTE: the buffer and shifter are reset too, so a discarded word can never leak onto the line.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_buf       <= '0;
         r_sh        <= '0;
         r_buf_full  <= 1'b0;
         r_neg_stage <= 1'b0;
         r_frame     <= 1'b0;
         r_sof       <= 1'b0;
      end else begin
         r_buf       <= w_buf_nxt;
         r_sh        <= w_sh_nxt;
         r_buf_full  <= w_buf_full_nxt;
         r_neg_stage <= w_neg_stage_nxt;
         r_frame     <= w_frame_nxt;
         r_sof       <= w_sof_nxt;
      end
   end

`ifdef DDR_PARITY_EN
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) r_par <= 1'b0;
      else         r_par <= w_par_nxt;
   end
`endif

   ddr_out_cell u_out (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_pos_d (w_pos_d),
      .i_neg_d (r_neg_stage),
      .o_q_pos (o_q_pos),
      .o_q_neg (o_q_neg),
      .o_ddr   (o_ddr)
   );

   assign o_frame = r_frame;
   assign o_sof   = r_sof;
endmodule

// File: tb/tb_ddr_serializer.sv
// Self-checking bench for ddr_serializer: directed scenarios plus a randomized stream
// reconstructed from the line and compared with a bit-list model of each word.
module tb_ddr_serializer;
   localparam int DW  = 8;
`ifdef DDR_PARITY_EN
   localparam int CYC = DW / 2 + 1;
`else
   localparam int CYC = DW / 2;
`endif
   localparam int NW  = 50;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   logic ddr, q_pos, q_neg, frame, sof;
   int   n_checks = 0;
   int   n_pass   = 0;
   logic [DW-1:0] exp_q[$];

   always #5 clk = ~clk;

   ddr_serializer_if #(.DW(DW)) hs_if ();

   ddr_serializer #(.DW(DW)) dut (
      .i_clk   (clk),
      .i_rstn  (rstn),
      .s_if    (hs_if),
      .o_ddr   (ddr),
      .o_q_pos (q_pos),
      .o_q_neg (q_neg),
      .o_frame (frame),
      .o_sof   (sof)
   );

   // Expected line content of one word, in send order (two entries per cycle).
   function automatic logic [2*CYC-1:0] line_bits(input logic [DW-1:0] w);
      logic [2*CYC-1:0] lb;
      lb = '0;
      lb[DW-1:0] = w;
`ifdef DDR_PARITY_EN
      lb[DW]     = ^w;
      lb[DW+1]   = ~(^w);
`endif
      return lb;
   endfunction

   // Checks CYC frame cycles starting at the next posedge.
   task automatic expect_word(input string tag, input logic [DW-1:0] w);
      logic [2*CYC-1:0] lb;
      logic [3:0] want_hi;
      logic [1:0] want_lo;
      lb = line_bits(w);
      for (int k = 0; k < CYC; k++) begin
         @(posedge clk); #1;
         want_hi = {lb[2*k], lb[2*k], 1'b1, (k == 0)};
         n_checks++;
         if ({ddr, q_pos, frame, sof} !== want_hi)
            $display("FAIL %s hi cyc%0d: ddr/qpos/frame/sof got %b want %b", tag, k, {ddr, q_pos, frame, sof}, want_hi);
         else n_pass++;
         @(negedge clk); #1;
         want_lo = {lb[2*k+1], lb[2*k+1]};
         n_checks++;
         if ({ddr, q_neg} !== want_lo)
            $display("FAIL %s lo cyc%0d: ddr/qneg got %b want %b", tag, k, {ddr, q_neg}, want_lo);
         else n_pass++;
      end
   endtask

   // Sends one isolated word from an idle line and checks it plus the idle line after it.
   task automatic send_one(input string tag, input logic [DW-1:0] w);
      @(posedge clk); #1;
      hs_if.i_data  = w;
      hs_if.i_valid = 1'b1;
      @(posedge clk); #1;
      hs_if.i_valid = 1'b0;
      n_checks++;
      if (hs_if.o_ready !== 1'b0) $display("FAIL %s ready_busy: got %b want 0", tag, hs_if.o_ready);
      else n_pass++;
      expect_word(tag, w);
      @(posedge clk); #1;
      n_checks++;
      if ({ddr, q_pos, frame, sof, hs_if.o_ready} !== 5'b00001)
         $display("FAIL %s idle_hi: ddr/qpos/frame/sof/ready got %b want 00001", tag, {ddr, q_pos, frame, sof, hs_if.o_ready});
      else n_pass++;
      @(negedge clk); #1;
      n_checks++;
      if ({ddr, q_neg} !== 2'b00) $display("FAIL %s idle_lo: ddr/qneg got %b want 00", tag, {ddr, q_neg});
      else n_pass++;
   endtask

   task automatic test_reset();
      rstn          = 1'b0;
      hs_if.i_valid = 1'b0;
      hs_if.i_data  = '0;
      for (int c = 0; c < 7; c++) begin
         if (c == 4) rstn = 1'b1;
         @(posedge clk); #1;
         n_checks++;
         if ({ddr, q_pos, q_neg, frame, sof, hs_if.o_ready} !== 6'b000001)
            $display("FAIL reset_hi c%0d: ddr/qpos/qneg/frame/sof/ready got %b want 000001", c, {ddr, q_pos, q_neg, frame, sof, hs_if.o_ready});
         else n_pass++;
         @(negedge clk); #1;
         n_checks++;
         if ({ddr, q_pos, q_neg, frame, sof, hs_if.o_ready} !== 6'b000001)
            $display("FAIL reset_lo c%0d: ddr/qpos/qneg/frame/sof/ready got %b want 000001", c, {ddr, q_pos, q_neg, frame, sof, hs_if.o_ready});
         else n_pass++;
      end
   endtask

   task automatic test_single();
      send_one("single_b4", 8'hB4);
   endtask

   task automatic test_back_to_back();
      logic want_rdy[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      @(posedge clk); #1;
      hs_if.i_data  = 8'hFF;
      hs_if.i_valid = 1'b1;
      @(posedge clk); #1;
      hs_if.i_data  = 8'h00;
      fork
         begin
            expect_word("b2b_ff", 8'hFF);
            expect_word("b2b_00", 8'h00);
         end
         begin
            for (int k = 0; k < 6; k++) begin
               if (k > 0) begin @(posedge clk); #1; end
               n_checks++;
               if (hs_if.o_ready !== want_rdy[k])
                  $display("FAIL b2b_ready k%0d: got %b want %b", k, hs_if.o_ready, want_rdy[k]);
               else n_pass++;
               if (k == 2) hs_if.i_valid = 1'b0;
            end
         end
      join
      @(posedge clk); #1;
      n_checks++;
      if ({ddr, frame, sof} !== 3'b000) $display("FAIL b2b_idle: ddr/frame/sof got %b want 000", {ddr, frame, sof});
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] wa;
      wa = 8'hA5;
      @(posedge clk); #1;
      hs_if.i_data  = wa;
      hs_if.i_valid = 1'b1;
      @(posedge clk); #1;            // A5 accepted
      hs_if.i_data  = 8'h99;
      @(posedge clk); #1;            // A5 loaded, bits 0/1
      @(posedge clk); #1;            // 99 accepted into the buffer
      hs_if.i_valid = 1'b0;
      @(posedge clk); #1;            // bits 4/5 of A5
      n_checks++;
      if (ddr !== wa[4]) $display("FAIL rmid_bit4: got %b want %b", ddr, wa[4]);
      else n_pass++;
      @(negedge clk); #1;
      n_checks++;
      if (ddr !== wa[5]) $display("FAIL rmid_bit5: got %b want %b", ddr, wa[5]);
      else n_pass++;
      rstn = 1'b0;
      #1;
      n_checks++;
      if ({ddr, q_pos, q_neg, frame, sof, hs_if.o_ready} !== 6'b000001)
         $display("FAIL rmid_async: ddr/qpos/qneg/frame/sof/ready got %b want 000001", {ddr, q_pos, q_neg, frame, sof, hs_if.o_ready});
      else n_pass++;
      @(posedge clk); #1;
      @(negedge clk); #1;
      rstn = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         n_checks++;
         if ({ddr, frame, sof, hs_if.o_ready} !== 4'b0001)
            $display("FAIL rmid_flushed c%0d: ddr/frame/sof/ready got %b want 0001", c, {ddr, frame, sof, hs_if.o_ready});
         else n_pass++;
      end
      send_one("rmid_3c", 8'h3C);
   endtask

   task automatic test_random();
      int got;
      int nb;
      logic [2*CYC-1:0] acc;
      logic [DW-1:0] w;
      logic [2*CYC-1:0] want;
      got = 0;
      nb  = 0;
      acc = '0;
      fork
         begin
            for (int i = 0; i < NW; i++) begin
               int idle;
               int waited;
               idle = $urandom_range(0, 3);
               for (int g = 0; g < idle; g++) begin @(posedge clk); #1; end
               w = DW'($urandom());
               hs_if.i_data  = w;
               hs_if.i_valid = 1'b1;
               waited = 0;
               while (hs_if.o_ready !== 1'b1 && waited < 100) begin
                  @(posedge clk); #1;
                  waited++;
               end
               if (waited >= 100) begin
                  n_checks++;
                  $display("FAIL random_accept word%0d: ready stuck at %b want 1", i, hs_if.o_ready);
                  hs_if.i_valid = 1'b0;
                  break;
               end
               @(posedge clk); #1;
               exp_q.push_back(w);
               hs_if.i_valid = 1'b0;
            end
         end
         begin
            for (int c = 0; c < NW * (CYC + 8) + 200 && got < NW; c++) begin
               @(posedge clk); #1;
               if (frame === 1'b1) begin
                  if (sof === 1'b1) begin
                     n_checks++;
                     if (nb != 0) $display("FAIL random_sof word%0d: sof after %0d bits want 0", got, nb);
                     else n_pass++;
                     nb = 0;
                  end
                  if (nb < 2 * CYC) acc[nb] = ddr;
                  @(negedge clk); #1;
                  if (nb + 1 < 2 * CYC) acc[nb+1] = ddr;
                  nb += 2;
                  if (nb == 2 * CYC) begin
                     n_checks++;
                     if (exp_q.size() == 0) begin
                        $display("FAIL random_word%0d: got %h with nothing expected", got, acc);
                     end else begin
                        want = line_bits(exp_q.pop_front());
                        if (acc !== want) $display("FAIL random_word%0d: got %h want %h", got, acc, want);
                        else n_pass++;
                     end
                     got++;
                     nb = 0;
                  end
               end
            end
         end
      join
      n_checks++;
      if (got != NW) $display("FAIL random_count: got %0d words want %0d", got, NW);
      else n_pass++;
   endtask

`ifdef DDR_PARITY_EN
   task automatic test_parity();
      send_one("parity_07", 8'h07);
   endtask
`endif

   initial begin
      hs_if.i_data  = '0;
      hs_if.i_valid = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_reset_mid();
      test_random();
`ifdef DDR_PARITY_EN
      test_parity();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
      $fatal(1, "timeout");
   end
endmodule
